// File: rtl/tdm_sel_ctrl.sv
// Time-division select controller driving the select of a 2:1 mux.
// Optional switch counter: define TDM_SWITCH_COUNT_EN to build it.
module tdm_sel_ctrl #(
  parameter int DWELL_W = 8,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               start,
  input  logic               stop,
  input  logic               load,
  input  logic [DWELL_W-1:0] dwell_a,
  input  logic [DWELL_W-1:0] dwell_b,
  output logic               s,
  output logic               sel_change,
  output logic               busy,
  output logic [CNT_W-1:0]   switch_count
);

  typedef enum logic [1:0] {
    IDLE,
    RUN_A,
    RUN_B
  } state_t;

  localparam logic [DWELL_W-1:0] ONE = 1;

  state_t state_q, state_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [DWELL_W-1:0] sha_q, shb_q;
  logic [DWELL_W-1:0] a_m1, b_m1;
  logic s_q, s_d;
  logic chg_q, chg_d;
  logic stop_pend_q, stop_pend_d;
  logic start_pend_q, start_pend_d;

  // A zero dwell behaves as a one-cycle dwell
  assign a_m1 = (sha_q == '0) ? '0 : sha_q - ONE;
  assign b_m1 = (shb_q == '0) ? '0 : shb_q - ONE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      sha_q        <= ONE;
      shb_q        <= ONE;
      s_q          <= 1'b0;
      chg_q        <= 1'b0;
      stop_pend_q  <= 1'b0;
      start_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      s_q          <= s_d;
      chg_q        <= chg_d;
      stop_pend_q  <= stop_pend_d;
      start_pend_q <= start_pend_d;
      if (load) begin
        sha_q <= dwell_a;
        shb_q <= dwell_b;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    s_d          = s_q;
    chg_d        = 1'b0;
    stop_pend_d  = stop_pend_q;
    start_pend_d = start_pend_q;
    if (state_q != IDLE && stop)
      stop_pend_d = 1'b1;
    if (en) begin
      unique case (state_q)
        IDLE: begin
          start_pend_d = 1'b0;
          stop_pend_d  = 1'b0;
          if ((start || start_pend_q) && !stop) begin
            state_d = RUN_A;
            cnt_d   = a_m1;
          end
        end
        RUN_A: begin
          if (cnt_q == '0) begin
            state_d = RUN_B;
            s_d     = 1'b1;
            cnt_d   = b_m1;
            chg_d   = 1'b1;
          end else begin
            cnt_d = cnt_q - ONE;
          end
        end
        RUN_B: begin
          if (cnt_q == '0) begin
            s_d   = 1'b0;
            chg_d = 1'b1;
            if (stop_pend_q || stop) begin
              state_d     = IDLE;
              stop_pend_d = 1'b0;
            end else begin
              state_d = RUN_A;
              cnt_d   = a_m1;
            end
          end else begin
            cnt_d = cnt_q - ONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q == IDLE) begin
      // Hold a start request across a freeze
      if (stop)
        start_pend_d = 1'b0;
      else if (start)
        start_pend_d = 1'b1;
    end
  end

  assign s          = s_q;
  assign sel_change = chg_q;
  assign busy       = (state_q != IDLE);

`ifdef TDM_SWITCH_COUNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  logic [CNT_W-1:0] sw_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      sw_cnt_q <= '0;
    else if (chg_d)
      sw_cnt_q <= sw_cnt_q + CNT_ONE;
  end

  assign switch_count = sw_cnt_q;
`else
  assign switch_count = '0;
`endif

endmodule
